// File: rtl/generic_rf_pkg.sv
// Shared types and helpers for the two-port register file with clear engine.
package generic_rf_pkg;

  // Controller states: CLEAR sweeps the array, READY serves accesses.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  // Lane merge for one bit: take the new bit when its lane is enabled,
  // otherwise keep the old bit.
  function automatic logic lane_merge_bit(input logic sel,
                                          input logic new_bit,
                                          input logic old_bit);
    logic res;
    if (sel) begin
      res = new_bit;
    end else begin
      res = old_bit;
    end
    return res;
  endfunction

endpackage

// File: rtl/generic_rf_core.sv
// Storage array with a lane-masked write port and a combinational read port.
// The array is deliberately not reset; the controller's clear sweep
// initialises it.
module generic_rf_core
  import generic_rf_pkg::*;
#(
  parameter int MEM_SIZE = 1024,
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int LANES    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [LANES-1:0] wbe,
  input  logic [AW-1:0]    raddr,
  output logic [DW-1:0]    rdata
);

  localparam int LW = DW / LANES;

  logic [DW-1:0] mem [MEM_SIZE];

  // Lane-masked write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wbe[i]) begin
        mem[waddr][i*LW +: LW] <= wdata[i*LW +: LW];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/generic_2p_rf_clr.sv
// Two-port register file with a hardware clear sweep, write-first bypass,
// address range checking and an optional output register.
module generic_2p_rf_clr
  import generic_rf_pkg::*;
#(
  parameter int            MEM_SIZE = 1024,
  parameter int            AW       = 10,
  parameter int            DW       = 32,
  parameter int            LANES    = 4,
  parameter int            OUT_REG  = 0,
  parameter logic [DW-1:0] CLR_VAL  = {DW{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_me_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [LANES-1:0] wr_be,
  input  logic             rd_me_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             clr_req,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic             init_busy,
  output logic             addr_err
);

  localparam int            LW         = DW / LANES;
  localparam logic [AW:0]   MEM_SIZE_W = (AW+1)'(MEM_SIZE);
  localparam logic [AW-1:0] MEM_LAST   = AW'(MEM_SIZE - 1);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
  logic             init_busy_q, init_busy_d;
  logic             valid1_q, valid1_d;
  logic [DW-1:0]    data1_q, data1_d;
  logic             addr_err_q, addr_err_d;

  logic             core_we;
  logic [AW-1:0]    core_waddr;
  logic [DW-1:0]    core_wdata;
  logic [LANES-1:0] core_be;
  logic [DW-1:0]    mem_rdata;
  logic [DW-1:0]    byp_data;
  logic             wr_in_range, rd_in_range, wr_acc, rd_acc, collide;

  generic_rf_core #(
    .MEM_SIZE (MEM_SIZE),
    .AW       (AW),
    .DW       (DW),
    .LANES    (LANES)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .wbe   (core_be),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  // Access qualification: range checks, acceptance (READY only) and collision.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < MEM_SIZE_W);
    rd_in_range = ({1'b0, rd_addr} < MEM_SIZE_W);
    wr_acc      = (state_q == READY) && wr_me_en;
    rd_acc      = (state_q == READY) && rd_me_en;
    collide     = wr_acc && wr_in_range && (wr_addr == rd_addr);
  end

  // Controller FSM: clear sweep drives the write port, READY forwards writes.
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    core_we    = 1'b0;
    core_waddr = wr_addr;
    core_wdata = wr_data;
    core_be    = wr_be;
    case (state_q)
      CLEAR: begin
        core_we    = 1'b1;
        core_waddr = clr_ptr_q;
        core_wdata = CLR_VAL;
        core_be    = {LANES{1'b1}};
        if (clr_ptr_q == MEM_LAST) begin
          state_d   = READY;
          clr_ptr_d = {AW{1'b0}};
        end else begin
          clr_ptr_d = clr_ptr_q + AW'(1);
        end
      end
      READY: begin
        // The access of this cycle still completes when a clear is requested.
        core_we = wr_acc && wr_in_range;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_ptr_d = {AW{1'b0}};
        end else begin
          state_d   = READY;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = {AW{1'b0}};
      end
    endcase
    init_busy_d = (state_d == CLEAR);
  end

  // Read stage: write-first bypass per lane, zero for out-of-range reads,
  // hold the last data when no read is accepted.
  always_comb begin
    byp_data = mem_rdata;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LW; j++) begin
        byp_data[i*LW + j] = lane_merge_bit(collide && wr_be[i],
                                            wr_data[i*LW + j],
                                            mem_rdata[i*LW + j]);
      end
    end
    if (rd_acc) begin
      valid1_d = 1'b1;
      if (rd_in_range) begin
        data1_d = byp_data;
      end else begin
        data1_d = {DW{1'b0}};
      end
    end else begin
      valid1_d = 1'b0;
      data1_d  = data1_q;
    end
    addr_err_d = (wr_acc && !wr_in_range) || (rd_acc && !rd_in_range);
  end

  // State, clear pointer and first read stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= {AW{1'b0}};
      init_busy_q <= 1'b1;
      valid1_q    <= 1'b0;
      data1_q     <= {DW{1'b0}};
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      init_busy_q <= init_busy_d;
      valid1_q    <= valid1_d;
      data1_q     <= data1_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign init_busy = init_busy_q;
  assign addr_err  = addr_err_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic          valid2_q, valid2_d;
    logic [DW-1:0] data2_q, data2_d;

    // Second read stage: forward the first stage, holding data when idle.
    always_comb begin
      valid2_d = valid1_q;
      if (valid1_q) begin
        data2_d = data1_q;
      end else begin
        data2_d = data2_q;
      end
    end

    // Output register for the two-cycle latency configuration.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid2_q <= 1'b0;
        data2_q  <= {DW{1'b0}};
      end else begin
        valid2_q <= valid2_d;
        data2_q  <= data2_d;
      end
    end

    assign rd_valid = valid2_q;
    assign rd_data  = data2_q;
  end else begin : g_no_out_reg
    assign rd_valid = valid1_q;
    assign rd_data  = data1_q;
  end

endmodule

// File: tb/tb_generic_2p_rf_clr.sv
// Directed bench: dut_a (12 entries, 1-cycle latency, non-zero clear value)
// and dut_b (16 entries, 2-cycle latency) share all stimulus.
module tb_generic_2p_rf_clr;

  localparam logic [31:0] CLR_A = 32'hC1C1_C1C1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_me_en = 1'b0, rd_me_en = 1'b0, clr_req = 1'b0;
  logic [3:0]  wr_addr = 4'd0, rd_addr = 4'd0, wr_be = 4'h0;
  logic [31:0] wr_data = 32'h0;

  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, init_busy_a, init_busy_b, addr_err_a, addr_err_b;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  generic_2p_rf_clr #(.MEM_SIZE(12), .AW(4), .DW(32), .LANES(4), .OUT_REG(0),
                      .CLR_VAL(CLR_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_me_en(wr_me_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_me_en(rd_me_en), .rd_addr(rd_addr),
    .clr_req(clr_req), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .init_busy(init_busy_a), .addr_err(addr_err_a));

  generic_2p_rf_clr #(.MEM_SIZE(16), .AW(4), .DW(32), .LANES(4), .OUT_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_me_en(wr_me_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .rd_me_en(rd_me_en), .rd_addr(rd_addr),
    .clr_req(clr_req), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .init_busy(init_busy_b), .addr_err(addr_err_b));

  task automatic idle();
    wr_me_en = 1'b0; rd_me_en = 1'b0; clr_req = 1'b0; wr_be = 4'h0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_me_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_me_en = 1'b0; wr_be = 4'h0;
  endtask

  // Issue one read and sample dut_a one cycle later.
  task automatic read_a(input logic [3:0] a, output logic v, output logic [31:0] d, output logic e);
    rd_me_en = 1'b1; rd_addr = a;
    @(negedge clk);
    v = rd_valid_a; d = rd_data_a; e = addr_err_a;
    rd_me_en = 1'b0;
  endtask

  task automatic test_reset();
    int cnt_a, cnt_b;
    logic v, e;
    logic [31:0] d;
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({init_busy_a, rd_valid_a, addr_err_a, rd_data_a} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL reset_a: busy=%b valid=%b err=%b data=%h, want 1 0 0 00000000",
               init_busy_a, rd_valid_a, addr_err_a, rd_data_a);
    end
    tests_run++;
    if ({init_busy_b, rd_valid_b, addr_err_b, rd_data_b} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL reset_b: busy=%b valid=%b err=%b data=%h, want 1 0 0 00000000",
               init_busy_b, rd_valid_b, addr_err_b, rd_data_b);
    end
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (init_busy_a) cnt_a++;
      if (init_busy_b) cnt_b++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt_a !== 12) begin
      failed++; $display("FAIL init_len_a: got %0d cycles, want 12", cnt_a);
    end
    tests_run++;
    if (cnt_b !== 16) begin
      failed++; $display("FAIL init_len_b: got %0d cycles, want 16", cnt_b);
    end
    for (int i = 0; i < 12; i++) begin
      read_a(4'(i), v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== CLR_A) begin
        failed++; $display("FAIL init_val addr %0d: valid=%b data=%h, want 1 %h", i, v, d, CLR_A);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_lanes();
    do_write(4'd3, 32'h1111_1111, 4'hF);
    do_write(4'd3, 32'hAABB_CCDD, 4'b0101);
    do_write(4'd3, 32'hFFFF_FFFF, 4'b0000);
    rd_me_en = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    rd_me_en = 1'b0;
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h11BB_11DD) begin
      failed++; $display("FAIL lanes_a N+1: valid=%b data=%h, want 1 11bb11dd", rd_valid_a, rd_data_a);
    end
    tests_run++;
    if (rd_valid_b !== 1'b0) begin
      failed++; $display("FAIL lanes_b early: valid=%b, want 0", rd_valid_b);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 32'h11BB_11DD) begin
      failed++; $display("FAIL lanes_b N+2: valid=%b data=%h, want 1 11bb11dd", rd_valid_b, rd_data_b);
    end
    tests_run++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 32'h11BB_11DD) begin
      failed++; $display("FAIL hold_a: valid=%b data=%h, want 0 11bb11dd", rd_valid_a, rd_data_a);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    logic v, e;
    logic [31:0] d;
    do_write(4'd5, 32'h0000_0000, 4'hF);
    wr_me_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; wr_be = 4'b1100;
    rd_me_en = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    idle();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hDEAD_0000) begin
      failed++; $display("FAIL bypass_a: valid=%b data=%h, want 1 dead0000", rd_valid_a, rd_data_a);
    end
    @(negedge clk);
    tests_run++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 32'hDEAD_0000) begin
      failed++; $display("FAIL bypass_b: valid=%b data=%h, want 1 dead0000", rd_valid_b, rd_data_b);
    end
    read_a(4'd5, v, d, e);
    tests_run++;
    if (v !== 1'b1 || d !== 32'hDEAD_0000) begin
      failed++; $display("FAIL bypass_mem: valid=%b data=%h, want 1 dead0000", v, d);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_err();
    logic v, e;
    logic [31:0] d;
    do_write(4'd1, 32'hA5A5_A5A5, 4'hF);
    wr_me_en = 1'b1; wr_addr = 4'd13; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
    @(negedge clk);
    idle();
    tests_run++;
    if (addr_err_a !== 1'b1 || rd_valid_a !== 1'b0) begin
      failed++; $display("FAIL oor_wr: err=%b valid=%b, want 1 0", addr_err_a, rd_valid_a);
    end
    @(negedge clk);
    tests_run++;
    if (addr_err_a !== 1'b0) begin
      failed++; $display("FAIL oor_wr_pulse: err=%b, want 0", addr_err_a);
    end
    read_a(4'd13, v, d, e);
    tests_run++;
    if (v !== 1'b1 || d !== 32'h0 || e !== 1'b1) begin
      failed++; $display("FAIL oor_rd: valid=%b data=%h err=%b, want 1 00000000 1", v, d, e);
    end
    @(negedge clk);
    tests_run++;
    if (addr_err_a !== 1'b0 || rd_valid_a !== 1'b0) begin
      failed++; $display("FAIL oor_rd_pulse: err=%b valid=%b, want 0 0", addr_err_a, rd_valid_a);
    end
    wr_me_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h1234_5678; wr_be = 4'hF;
    rd_me_en = 1'b1; rd_addr = 4'd13;
    @(negedge clk);
    idle();
    tests_run++;
    if (addr_err_a !== 1'b1 || rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
      failed++; $display("FAIL oor_both: err=%b valid=%b data=%h, want 1 1 00000000",
                         addr_err_a, rd_valid_a, rd_data_a);
    end
    @(negedge clk);
    tests_run++;
    if (addr_err_a !== 1'b0) begin
      failed++; $display("FAIL oor_both_pulse: err=%b, want 0", addr_err_a);
    end
    // Back-to-back reads also confirm the dropped writes did not alias.
    rd_me_en = 1'b1; rd_addr = 4'd1;
    @(negedge clk);
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hA5A5_A5A5) begin
      failed++; $display("FAIL b2b_addr1: valid=%b data=%h, want 1 a5a5a5a5", rd_valid_a, rd_data_a);
    end
    rd_addr = 4'd5;
    @(negedge clk);
    rd_me_en = 1'b0;
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hDEAD_0000) begin
      failed++; $display("FAIL b2b_addr5: valid=%b data=%h, want 1 dead0000", rd_valid_a, rd_data_a);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    int cnt, bad;
    logic v, e;
    logic [31:0] d;
    do_write(4'd2, 32'h1234_5678, 4'hF);
    clr_req = 1'b1; rd_me_en = 1'b1; rd_addr = 4'd2;
    @(negedge clk);
    idle();
    tests_run++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h1234_5678 || init_busy_a !== 1'b1) begin
      failed++; $display("FAIL clr_read: valid=%b data=%h busy=%b, want 1 12345678 1",
                         rd_valid_a, rd_data_a, init_busy_a);
    end
    cnt = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (init_busy_a) begin
        cnt++;
        wr_me_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_me_en = 1'b1; rd_addr = 4'd0;
      end else begin
        idle();
      end
      @(negedge clk);
      if (rd_valid_a || addr_err_a) bad++;
    end
    idle();
    tests_run++;
    if (cnt !== 12) begin
      failed++; $display("FAIL clr_len: got %0d cycles, want 12", cnt);
    end
    tests_run++;
    if (bad !== 0) begin
      failed++; $display("FAIL clr_ignore: %0d cycles with valid/err, want 0", bad);
    end
    tests_run++;
    if (init_busy_b !== 1'b0) begin
      failed++; $display("FAIL clr_done_b: busy=%b, want 0", init_busy_b);
    end
    for (int i = 0; i < 12; i++) begin
      read_a(4'(i), v, d, e);
      tests_run++;
      if (v !== 1'b1 || d !== CLR_A) begin
        failed++; $display("FAIL clr_val addr %0d: valid=%b data=%h, want 1 %h", i, v, d, CLR_A);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    logic v, e;
    logic [31:0] d;
    clr_req = 1'b1;
    @(negedge clk);
    idle();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({init_busy_a, rd_valid_a, addr_err_a, rd_data_a} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      failed++;
      $display("FAIL midclr_reset: busy=%b valid=%b err=%b data=%h, want 1 0 0 00000000",
               init_busy_a, rd_valid_a, addr_err_a, rd_data_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (init_busy_a) cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (cnt !== 12) begin
      failed++; $display("FAIL midclr_len: got %0d cycles, want 12", cnt);
    end
    read_a(4'd0, v, d, e);
    tests_run++;
    if (v !== 1'b1 || d !== CLR_A) begin
      failed++; $display("FAIL midclr_val: valid=%b data=%h, want 1 %h", v, d, CLR_A);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lanes();
    test_collision();
    test_addr_err();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/generic_2p_rf_clr.md
GENERIC_2P_RF_CLR -- requirements
Module: generic_2p_rf_clr

Interface
REQ-001 Parameter MEM_SIZE, default 1024: number of entries.
REQ-002 Parameter AW, default 10: address width; the block SHALL support MEM_SIZE <= 2**AW.
REQ-003 Parameter DW, default 32: data width.
REQ-004 Parameter LANES, default 4: write-enable lanes; DW % LANES SHALL be 0, and lane width LW = DW/LANES.
REQ-005 Parameter OUT_REG, default 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
REQ-006 Parameter CLR_VAL, default all-zero DW bits: value written to every entry during clear.
REQ-007 clk, input, 1: single clock for all logic; all flops update on the rising edge.
REQ-008 rst_n, input, 1: asynchronous, active-low reset.
REQ-009 wr_me_en, input, 1: write request.
REQ-010 wr_addr, input, AW: write address.
REQ-011 wr_data, input, DW: write data.
REQ-012 wr_be, input, LANES: per-lane write enable; lane i covers bits [i*LW +: LW].
REQ-013 rd_me_en, input, 1: read request.
REQ-014 rd_addr, input, AW: read address.
REQ-015 clr_req, input, 1: single-cycle pulse requesting a full clear.
REQ-016 rd_data, output, DW: read data.
REQ-017 rd_valid, output, 1: one-cycle pulse qualifying rd_data.
REQ-018 init_busy, output, 1: high while a clear is in progress.
REQ-019 addr_err, output, 1: one-cycle pulse on an accepted access to an address >= MEM_SIZE.

Function
REQ-020 The FSM SHALL have two states: CLEAR and READY.
REQ-021 CLEAR: each cycle, clr_ptr is written with CLR_VAL on all lanes, then incremented; after clr_ptr == MEM_SIZE-1 is written, the FSM SHALL go to READY, taking exactly MEM_SIZE cycles.
REQ-022 READY: clr_req = 1 SHALL reset clr_ptr to 0 and go to CLEAR on the next edge; clr_req SHALL be ignored in CLEAR.
REQ-023 While init_busy = 1, wr_me_en and rd_me_en SHALL be ignored: no memory update, no rd_valid, no addr_err.
REQ-024 Write in READY: wr_me_en = 1 with wr_addr < MEM_SIZE SHALL update only lanes with wr_be[i] = 1 at the edge; wr_be = 0 SHALL be a no-op.
REQ-025 A read accepted at edge N SHALL present rd_data and rd_valid = 1 during cycle N+1 (OUT_REG=0) or N+2 (OUT_REG=1), one result per accepted read, fully pipelined.
REQ-026 rd_data SHALL hold its last value when rd_valid = 0.
REQ-027 Read/write same-address same-cycle collision: rd_data lane i SHALL be wr_data lane i if wr_be[i] = 1, else the previous memory content (write-first bypass).
REQ-028 Out-of-range write (addr >= MEM_SIZE) SHALL be dropped and pulse addr_err.
REQ-029 Out-of-range read SHALL return 0 with rd_valid = 1 and pulse addr_err, aligned with the request edge.
REQ-030 A simultaneous out-of-range read and write SHALL produce a single addr_err pulse.
REQ-031 A clr_req in the same cycle as an access in READY SHALL let that access complete (write performed, read returned) before clearing.

Reset
REQ-032 On rst_n = 0: FSM = CLEAR, clr_ptr = 0, init_busy = 1, rd_valid = 0, rd_data = 0, addr_err = 0, and the read pipeline is flushed.
REQ-033 Memory array SHALL have no reset; the clear after rst_n deasserts initialises it.
REQ-034 Reset asserted mid-clear or mid-read SHALL abort the operation; the clear restarts from address 0.

Structure
REQ-035 Package generic_rf_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the lane-merge function.
REQ-036 One sub-module, generic_rf_core, SHALL hold the storage array, the lane-masked write and the unregistered read port; the top holds the FSM, bypass, range check and output pipeline.

Verification
REQ-037 Release reset with MEM_SIZE=16 -> init_busy high for exactly 16 cycles; then reading each of addr 0..15 returns CLR_VAL.
REQ-038 Write 0xAABBCCDD to addr 3 with wr_be=4'b0101 over 0x11111111 -> read returns 0x11BB11DD at N+1 (OUT_REG=0) and at N+2 (OUT_REG=1).
REQ-039 Same cycle: write addr 5 data 0xDEADBEEF with be=4'b1100, read addr 5 over old 0x0 -> rd_data = 0xDEAD0000.
REQ-040 MEM_SIZE=12, AW=4: write then read addr 13 -> one addr_err pulse each, memory unchanged, rd_data = 0 with rd_valid.
REQ-041 clr_req with read addr 2 in the same cycle -> read returns old data, then init_busy high for MEM_SIZE cycles, reads during clear give no rd_valid, and all entries are CLR_VAL afterwards.
REQ-042 Assert rst_n = 0 halfway through a clear -> outputs reset immediately; after release, init_busy stays high for a full MEM_SIZE cycles.
